labfinalsoc_control_pio: RTL and testbench

LABFINALSOC_CONTROL_PIO -- requirements
Module: labfinalsoc_control_pio

---
 rtl/labfinalsoc_pio_pkg.sv | 14 +
 rtl/labfinalsoc_pio_handshake.sv | 59 +++++
 rtl/labfinalsoc_control_pio.sv | 116 +++++++++++
 tb/tb_labfinalsoc_control_pio.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/labfinalsoc_pio_pkg.sv
// Register map and STATUS bit positions shared by the control PIO and its handshake tracker.
package labfinalsoc_pio_pkg;

    localparam logic [2:0] OFF_DATA     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_IRQMASK  = 3'd2;
    localparam logic [2:0] OFF_OUTSET   = 3'd4;
    localparam logic [2:0] OFF_OUTCLEAR = 3'd5;

    localparam int ST_PENDING  = 0;
    localparam int ST_ACK_SEEN = 1;
    localparam int ST_OVERRUN  = 2;

endpackage

// File: rtl/labfinalsoc_pio_handshake.sv
// Tracks the out_valid/out_ack handshake: pending flag plus sticky ack_seen and overrun flags.
module labfinalsoc_pio_handshake (
    input  logic clk,
    input  logic reset_n,
    input  logic data_wr,
    input  logic out_ack,
    input  logic clr_ack_seen,
    input  logic clr_overrun,
    output logic pending,
    output logic ack_seen,
    output logic overrun
);

    logic pending_q, pending_d;
    logic ack_seen_q, ack_seen_d;
    logic overrun_q, overrun_d;
    logic ack_fire;

    assign ack_fire = pending_q & out_ack;

    // A new DATA write always re-arms pending; a new ack beats a software clear.
    always_comb begin
        pending_d  = pending_q;
        ack_seen_d = ack_seen_q;
        overrun_d  = overrun_q;

        if (data_wr)
            pending_d = 1'b1;
        else if (ack_fire)
            pending_d = 1'b0;

        if (ack_fire)
            ack_seen_d = 1'b1;
        else if (clr_ack_seen)
            ack_seen_d = 1'b0;

        if (data_wr && pending_q && !ack_fire)
            overrun_d = 1'b1;
        else if (clr_overrun)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 1'b0;
            ack_seen_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            ack_seen_q <= ack_seen_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pending  = pending_q;
    assign ack_seen = ack_seen_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/labfinalsoc_control_pio.sv
// Avalon-MM control PIO feeding game logic with a valid/ack handshake.
// Define LABFINALSOC_CONTROL_PIO_IRQ_EN to build the IRQMASK register and irq output.
module labfinalsoc_control_pio
    import labfinalsoc_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  irq
);

    logic                  wr_en;
    logic                  data_wr;
    logic                  clr_ack_seen;
    logic                  clr_overrun;
    logic                  pending, ack_seen, overrun;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d  = data_q;
        data_wr = 1'b0;
        if (wr_en) begin
            case (address)
                OFF_DATA:     begin data_d = wd_data;           data_wr = 1'b1; end
                OFF_OUTSET:   begin data_d = data_q | wd_data;  data_wr = 1'b1; end
                OFF_OUTCLEAR: begin data_d = data_q & ~wd_data; data_wr = 1'b1; end
                default:      ;
            endcase
        end
    end

    assign clr_ack_seen = wr_en && (address == OFF_STATUS) && writedata[ST_ACK_SEEN];
    assign clr_overrun  = wr_en && (address == OFF_STATUS) && writedata[ST_OVERRUN];

    labfinalsoc_pio_handshake u_handshake (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_wr      (data_wr),
        .out_ack      (out_ack),
        .clr_ack_seen (clr_ack_seen),
        .clr_overrun  (clr_overrun),
        .pending      (pending),
        .ack_seen     (ack_seen),
        .overrun      (overrun)
    );

`ifdef LABFINALSOC_CONTROL_PIO_IRQ_EN
    logic irqmask_q, irqmask_d;

    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en && (address == OFF_IRQMASK))
            irqmask_d = writedata[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irqmask_q <= 1'b0;
        else
            irqmask_q <= irqmask_d;
    end

    assign irq = ack_seen & irqmask_q;
`else
    assign irq = 1'b0;
`endif

    // Read data is registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            OFF_DATA:    readdata_d[DATA_WIDTH-1:0] = data_q;
            OFF_STATUS: begin
                readdata_d[ST_PENDING]  = pending;
                readdata_d[ST_ACK_SEEN] = ack_seen;
                readdata_d[ST_OVERRUN]  = overrun;
            end
`ifdef LABFINALSOC_CONTROL_PIO_IRQ_EN
            OFF_IRQMASK: readdata_d[0] = irqmask_q;
`endif
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE[DATA_WIDTH-1:0];
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port  = data_q;
    assign out_valid = pending;
    assign readdata  = readdata_q;

endmodule

// File: tb/tb_labfinalsoc_control_pio.sv
// Self-checking bench for labfinalsoc_control_pio: directed scenarios plus randomized traffic vs. a register-level model.
module tb_labfinalsoc_control_pio;

    localparam int          DW  = 8;
    localparam logic [31:0] RST = 32'h0000_003C;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          out_valid;
    logic          out_ack;
    logic          irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state, described in terms of the visible register map
    logic [DW-1:0] m_data;
    logic          m_pend, m_ack, m_over, m_mask;
    logic [31:0]   exp_rd;

    labfinalsoc_control_pio #(.DATA_WIDTH(DW), .RESET_VALUE(RST)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {{(32-DW){1'b0}}, m_data};
            3'd1: return {29'b0, m_over, m_ack, m_pend};
`ifdef LABFINALSOC_CONTROL_PIO_IRQ_EN
            3'd2: return {31'b0, m_mask};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
`ifdef LABFINALSOC_CONTROL_PIO_IRQ_EN
        return m_ack & m_mask;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_data = RST[DW-1:0];
        m_pend = 0; m_ack = 0; m_over = 0; m_mask = 0;
        exp_rd = 32'h0;
    endtask

    // One bus cycle: drive, take the edge, advance the model, settle 1 time unit past the edge.
    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] wd, input logic ack);
        logic wr, fire, dw;
        chipselect = cs; write_n = wn; address = a; writedata = wd; out_ack = ack;
        @(posedge clk);
        exp_rd = model_read(a);
        wr   = cs && !wn;
        fire = m_pend && ack;
        dw   = wr && (a == 3'd0 || a == 3'd4 || a == 3'd5);
        if (dw && m_pend && !fire) m_over = 1;
        else if (wr && a == 3'd1 && wd[2]) m_over = 0;
        if (fire) m_ack = 1;
        else if (wr && a == 3'd1 && wd[1]) m_ack = 0;
        if (dw) m_pend = 1;
        else if (fire) m_pend = 0;
        if (wr && a == 3'd0) m_data = wd[DW-1:0];
        if (wr && a == 3'd4) m_data = m_data | wd[DW-1:0];
        if (wr && a == 3'd5) m_data = m_data & ~wd[DW-1:0];
`ifdef LABFINALSOC_CONTROL_PIO_IRQ_EN
        if (wr && a == 3'd2) m_mask = wd[0];
`endif
        #1;
    endtask

    task automatic idle(); cycle(0, 1, 3'd0, 32'h0, 0); endtask
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic ack);
        cycle(1, 0, a, wd, ack);
    endtask
    task automatic rd_reg(input logic [2:0] a); cycle(1, 1, a, 32'h0, 0); endtask

    task automatic test_reset();
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; out_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (out_port !== RST[DW-1:0]) $display("FAIL reset_out_port got=%h exp=%h", out_port, RST[DW-1:0]); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=0", readdata); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else pass_cnt++;
        @(negedge clk); reset_n = 1;
        rd_reg(3'd1);
        total_cnt++; if (readdata !== 32'h0) $display("FAIL reset_status got=%h exp=0", readdata); else pass_cnt++;
    endtask

    task automatic test_data_write();
        wr_reg(3'd0, 32'h0000_00A5, 0);
        total_cnt++; if (out_port !== 8'hA5) $display("FAIL data_out_port got=%h exp=a5", out_port); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL data_out_valid got=%b exp=1", out_valid); else pass_cnt++;
        rd_reg(3'd0);
        total_cnt++; if (readdata !== 32'h0000_00A5) $display("FAIL data_readback got=%h exp=000000a5", readdata); else pass_cnt++;
    endtask

    task automatic test_set_clear();
        wr_reg(3'd0, 32'h0000_00F0, 0);
        wr_reg(3'd4, 32'h0000_000F, 0);
        total_cnt++; if (out_port !== 8'hFF) $display("FAIL outset got=%h exp=ff", out_port); else pass_cnt++;
        wr_reg(3'd5, 32'h0000_0030, 0);
        total_cnt++; if (out_port !== 8'hCF) $display("FAIL outclear got=%h exp=cf", out_port); else pass_cnt++;
        wr_reg(3'd3, 32'hFFFF_FFFF, 0);
        rd_reg(3'd0);
        total_cnt++; if (readdata !== 32'h0000_00CF) $display("FAIL unmapped_write got=%h exp=000000cf", readdata); else pass_cnt++;
        rd_reg(3'd7);
        total_cnt++; if (readdata !== 32'h0) $display("FAIL unmapped_read got=%h exp=0", readdata); else pass_cnt++;
    endtask

    task automatic clean_status();
        cycle(0, 1, 3'd0, 32'h0, 1);
        wr_reg(3'd1, 32'h0000_0006, 0);
    endtask

    task automatic test_ack();
        clean_status();
        wr_reg(3'd0, 32'h0000_005A, 0);
        cycle(0, 1, 3'd0, 32'h0, 1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ack_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        cycle(0, 1, 3'd0, 32'h0, 1);
        rd_reg(3'd1);
        total_cnt++; if (readdata !== 32'h2) $display("FAIL ack_status got=%h exp=2", readdata); else pass_cnt++;
        wr_reg(3'd1, 32'h0000_0003, 0);
        rd_reg(3'd1);
        total_cnt++; if (readdata !== 32'h0) $display("FAIL w1c_status got=%h exp=0", readdata); else pass_cnt++;
    endtask

    task automatic test_overrun();
        wr_reg(3'd0, 32'h0000_0011, 0);
        wr_reg(3'd0, 32'h0000_0022, 0);
        total_cnt++; if (out_port !== 8'h22) $display("FAIL overrun_out_port got=%h exp=22", out_port); else pass_cnt++;
        rd_reg(3'd1);
        total_cnt++; if (readdata !== 32'h5) $display("FAIL overrun_status got=%h exp=5", readdata); else pass_cnt++;
        wr_reg(3'd1, 32'h0000_0004, 0);
        wr_reg(3'd0, 32'h0000_0033, 1);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL coincide_valid got=%b exp=1", out_valid); else pass_cnt++;
        rd_reg(3'd1);
        total_cnt++; if (readdata !== 32'h3) $display("FAIL coincide_status got=%h exp=3", readdata); else pass_cnt++;
    endtask

    task automatic test_w1c_race();
        wr_reg(3'd1, 32'h0000_0002, 1);
        rd_reg(3'd1);
        total_cnt++; if (readdata[1] !== 1'b1) $display("FAIL w1c_race_ack_seen got=%b exp=1", readdata[1]); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL w1c_race_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_irq();
        logic exp_i;
        wr_reg(3'd2, 32'h0000_0001, 0);
`ifdef LABFINALSOC_CONTROL_PIO_IRQ_EN
        exp_i = 1'b1;
`else
        exp_i = 1'b0;
`endif
        total_cnt++; if (irq !== exp_i) $display("FAIL irq_set got=%b exp=%b", irq, exp_i); else pass_cnt++;
        rd_reg(3'd2);
        total_cnt++; if (readdata !== {31'b0, exp_i}) $display("FAIL irqmask_read got=%h exp=%h", readdata, {31'b0, exp_i}); else pass_cnt++;
        wr_reg(3'd1, 32'h0000_0002, 0);
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0] a;
        for (int i = 0; i < 400; i++) begin
            a = 3'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom(),
                  1'($urandom_range(0, 2) == 0));
            total_cnt++;
            if (out_port !== m_data || out_valid !== m_pend || readdata !== exp_rd || irq !== model_irq())
                $display("FAIL random[%0d] got port=%h vld=%b rd=%h irq=%b exp port=%h vld=%b rd=%h irq=%b",
                         i, out_port, out_valid, readdata, irq, m_data, m_pend, exp_rd, model_irq());
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        wr_reg(3'd0, 32'h0000_0077, 0);
        rd_reg(3'd0);
        #2 reset_n = 0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL async_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_port !== RST[DW-1:0]) $display("FAIL async_out_port got=%h exp=%h", out_port, RST[DW-1:0]); else pass_cnt++;
        total_cnt++; if (readdata !== 32'h0) $display("FAIL async_readdata got=%h exp=0", readdata); else pass_cnt++;
        model_reset();
        chipselect = 0; write_n = 1; out_ack = 0;
        @(negedge clk); reset_n = 1;
        rd_reg(3'd1);
        total_cnt++; if (readdata !== 32'h0) $display("FAIL async_status got=%h exp=0", readdata); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_set_clear();
        test_ack();
        test_overrun();
        test_w1c_race();
        test_irq();
        test_random();
        test_async_reset();
        idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
